// File: rtl/sm4_axis_core_pkg.sv
// -----------------------------------------------------------------------------
// sm4_axis_core_pkg
// Shared types, opcode encodings, channel indices and the pure-function
// pieces of the SM4 round datapath (linear mixing and byte rotation).
// No ports; imported by the interface, the core and the S-box.
// -----------------------------------------------------------------------------
package sm4_axis_core_pkg;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;
    typedef logic [1:0]  bsel_t;

    // Operation encodings carried on the operation channel.
    localparam logic SM4_OP_ED = 1'b0;  // encrypt/decrypt linear transform L
    localparam logic SM4_OP_KS = 1'b1;  // key-schedule linear transform L'

    // Bit positions of the four input channels inside the core's
    // per-channel vectors (valid, ready, have, capture).
    localparam int CH_A  = 3;
    localparam int CH_B  = 2;
    localparam int CH_BS = 1;
    localparam int CH_OP = 0;

    // Linear transform for data rounds, applied to the zero-extended S-box byte.
    function automatic word_t mix_ed(input word_t y);
        return y ^ (y << 8) ^ (y << 2) ^ (y << 18)
                 ^ ((y & 32'h0000_003F) << 26)
                 ^ ((y & 32'h0000_00C0) << 10);
    endfunction

    // Linear transform for key-schedule rounds.
    function automatic word_t mix_ks(input word_t y);
        return y ^ ((y & 32'h0000_0007) << 29)
                 ^ ((y & 32'h0000_00FE) << 7)
                 ^ ((y & 32'h0000_0001) << 23)
                 ^ ((y & 32'h0000_00F8) << 13);
    endfunction

    // Rotate left by a whole number of bytes; moves the mixed word back
    // into the lane the S-box byte was taken from.
    function automatic word_t rotl_bytes(input word_t v, input bsel_t n);
        word_t r;
        case (n)
            2'd0:    r = v;
            2'd1:    r = {v[23:0], v[31:24]};
            2'd2:    r = {v[15:0], v[31:16]};
            default: r = {v[7:0],  v[31:8]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sm4_axis_core_if.sv
// -----------------------------------------------------------------------------
// sm4_axis_core_if
// Bundles the four AXI-Stream-style operand channels and the result channel.
//   s_axis_a_*         : rs1 operand (32 bit)
//   s_axis_b_*         : rs2 operand (32 bit)
//   s_axis_bs_*        : byte select (2 bit)
//   s_axis_operation_* : operation (1 bit, SM4_OP_ED / SM4_OP_KS)
//   m_axis_result_*    : result word plus a one-cycle valid pulse, no tready
// Modports: slave = the core, master = the requester.
// -----------------------------------------------------------------------------
interface sm4_axis_core_if;
    import sm4_axis_core_pkg::*;

    logic  s_axis_a_tvalid;
    logic  s_axis_a_tready;
    word_t s_axis_a_tdata;

    logic  s_axis_b_tvalid;
    logic  s_axis_b_tready;
    word_t s_axis_b_tdata;

    logic  s_axis_bs_tvalid;
    logic  s_axis_bs_tready;
    bsel_t s_axis_bs_tdata;

    logic  s_axis_operation_tvalid;
    logic  s_axis_operation_tready;
    logic  s_axis_operation_tdata;

    logic  m_axis_result_tvalid;
    word_t m_axis_result_tdata;

    modport slave (
        input  s_axis_a_tvalid, s_axis_a_tdata,
        output s_axis_a_tready,
        input  s_axis_b_tvalid, s_axis_b_tdata,
        output s_axis_b_tready,
        input  s_axis_bs_tvalid, s_axis_bs_tdata,
        output s_axis_bs_tready,
        input  s_axis_operation_tvalid, s_axis_operation_tdata,
        output s_axis_operation_tready,
        output m_axis_result_tvalid, m_axis_result_tdata
    );

    modport master (
        output s_axis_a_tvalid, s_axis_a_tdata,
        input  s_axis_a_tready,
        output s_axis_b_tvalid, s_axis_b_tdata,
        input  s_axis_b_tready,
        output s_axis_bs_tvalid, s_axis_bs_tdata,
        input  s_axis_bs_tready,
        output s_axis_operation_tvalid, s_axis_operation_tdata,
        input  s_axis_operation_tready,
        input  m_axis_result_tvalid, m_axis_result_tdata
    );

endinterface

// File: rtl/sm4_axis_core_sbox.sv
// -----------------------------------------------------------------------------
// sm4_axis_core_sbox
// Combinational SM4 S-box lookup (standard GB/T 32907 table).
//   x : 8-bit input byte
//   y : 8-bit substituted byte
// -----------------------------------------------------------------------------
module sm4_axis_core_sbox
    import sm4_axis_core_pkg::*;
(
    input  byte_t x,
    output byte_t y
);

    localparam byte_t SBOX_TABLE [256] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    assign y = SBOX_TABLE[x];

endmodule

// File: rtl/sm4_axis_core.sv
// -----------------------------------------------------------------------------
// sm4_axis_core
// One SM4 round-function step in the RISC-V Zksed style:
//   result = rs1 ^ rotl(L(sbox(rs2.byte[bs])), 8*bs)
// with L chosen by the operation channel (ED or KS).
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset
//   axis : sm4_axis_core_if.slave -- four independent operand channels,
//          each accepted once per operation, plus a result word with a
//          one-cycle valid pulse (no back-pressure on the result).
// Sequence: IDLE (collect operands) -> SBOX -> MIX -> DONE (pulse) -> IDLE.
// -----------------------------------------------------------------------------
module sm4_axis_core
    import sm4_axis_core_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    sm4_axis_core_if.slave axis
);

    typedef enum logic [1:0] {
        IDLE,
        SBOX,
        MIX,
        DONE
    } state_t;

    state_t     state;

    // Per-channel vectors, bit order given by CH_* in the package.
    logic [3:0] have_q;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] cap;

    word_t      rs1_q;
    word_t      rs2_q;
    bsel_t      bs_q;
    logic       op_q;
    word_t      y_q;
    word_t      z;
    word_t      result_q;
    logic       result_valid_q;
    byte_t      sbox_in;
    byte_t      sbox_out;

    // ------------------------------------------------------------------
    // Channel handshakes: a channel is ready only while idle and still
    // missing its operand, so busy-state tvalid is never captured.
    // ------------------------------------------------------------------
    assign valid[CH_A]  = axis.s_axis_a_tvalid;
    assign valid[CH_B]  = axis.s_axis_b_tvalid;
    assign valid[CH_BS] = axis.s_axis_bs_tvalid;
    assign valid[CH_OP] = axis.s_axis_operation_tvalid;

    assign ready = (state == IDLE) ? ~have_q : 4'b0000;
    assign cap   = valid & ready;

    assign axis.s_axis_a_tready         = ready[CH_A];
    assign axis.s_axis_b_tready         = ready[CH_B];
    assign axis.s_axis_bs_tready        = ready[CH_BS];
    assign axis.s_axis_operation_tready = ready[CH_OP];

    assign axis.m_axis_result_tvalid = result_valid_q;
    assign axis.m_axis_result_tdata  = result_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign sbox_in = rs2_q[{bs_q, 3'b000} +: 8];

    sm4_axis_core_sbox u_sbox (
        .x (sbox_in),
        .y (sbox_out)
    );

    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        z = '0;
        case (op_q)
            SM4_OP_ED: z = mix_ed(y_q);
            SM4_OP_KS: z = mix_ks(y_q);
        endcase
    end

    // NOTE: operand and intermediate registers carry no reset; they are
    // always written before being consumed, and reset only has to bring
    // the control state and visible outputs to a known value.
    always_ff @(posedge clk) begin
        if (cap[CH_A])  rs1_q <= axis.s_axis_a_tdata;
        if (cap[CH_B])  rs2_q <= axis.s_axis_b_tdata;
        if (cap[CH_BS]) bs_q  <= axis.s_axis_bs_tdata;
        if (cap[CH_OP]) op_q  <= axis.s_axis_operation_tdata;
        if (state == SBOX) y_q <= {24'h0, sbox_out};
    end

    // ------------------------------------------------------------------
    // Control FSM with registered result outputs.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples values from before the edge, independent of the
    // order of statements or blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            have_q         <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Leave as soon as the last outstanding operand lands,
                    // including the case where all four arrive together.
                    if (&(have_q | cap)) begin
                        state  <= SBOX;
                        have_q <= '0;
                    end else begin
                        have_q <= have_q | cap;
                    end
                end
                SBOX: state <= MIX;
                MIX: begin
                    result_q       <= rotl_bytes(z, bs_q) ^ rs1_q;
                    result_valid_q <= 1'b1;
                    state          <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sm4_axis_core.md
SM4_AXIS_CORE -- requirements
Module: Sm4AxisCore

Interface
REQ-001 SHALL have no parameters; widths are fixed by the shared package (word_t = 32 bits).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: s_axis_a_tvalid / s_axis_a_tready / s_axis_a_tdata  in/out/in  1/1/32  rs1 operand channel.
REQ-005 SHALL have ports: s_axis_b_tvalid / s_axis_b_tready / s_axis_b_tdata  in/out/in  1/1/32  rs2 operand channel.
REQ-006 SHALL have ports: s_axis_bs_tvalid / s_axis_bs_tready / s_axis_bs_tdata  in/out/in  1/1/2  byte-select channel.
REQ-007 SHALL have ports: s_axis_operation_tvalid / s_axis_operation_tready / s_axis_operation_tdata  in/out/in  1/1/1  op channel (0 = ED, 1 = KS).
REQ-008 SHALL have ports: m_axis_result_tvalid  out  1  one-cycle completion pulse; there is no tready.
REQ-009 SHALL have ports: m_axis_result_tdata  out  32  result word.

Function
REQ-010 SHALL run a state machine with states IDLE, SBOX, MIX and DONE.
REQ-011 In IDLE, each channel SHALL hold a have_x flag; tready_x SHALL equal (state == IDLE) && !have_x.
REQ-012 A channel SHALL capture tdata and set have_x on tvalid && tready; the four channels capture independently and in any order or cycle.
REQ-013 On the edge where the last missing flag would be set (or all four are already set), the state SHALL go IDLE->SBOX and all have_x flags SHALL clear.
REQ-014 SBOX: x = rs2 byte[bs*8+7:bs*8]; the block SHALL register y = zero-extended sbox(x); then go ->MIX.
REQ-015 MIX, ED: z = y ^ y<<8 ^ y<<2 ^ y<<18 ^ (y&0x3F)<<26 ^ (y&0xC0)<<10.
REQ-016 MIX, KS: z = y ^ (y&0x07)<<29 ^ (y&0xFE)<<7 ^ (y&0x01)<<23 ^ (y&0xF8)<<13.
REQ-017 MIX: the block SHALL register result = rotl32(z, bs*8) ^ rs1; then go ->DONE. All arithmetic is 32-bit and shifts truncate.
REQ-018 DONE: m_axis_result_tvalid SHALL be 1 for exactly this cycle; the state then goes ->IDLE.
REQ-019 Latency from capture edge to tvalid SHALL be 3 cycles; throughput is one operation per 4 cycles when channels are always valid.
REQ-020 m_axis_result_tdata SHALL hold the last result stable until the next MIX update.
REQ-021 All tready outputs SHALL be 0 in SBOX, MIX and DONE; tvalid asserted in those states SHALL be ignored, not captured.
REQ-022 A tvalid deasserted before capture SHALL leave have_x unchanged. Inputs SHALL NOT be required to stay stable after capture.
REQ-023 There is no flush port. The initiator SHALL NOT issue a new request until the pulse of any outstanding one is consumed or has elapsed; tready low while busy enforces this.

Reset
REQ-024 On rst the block SHALL set state to IDLE, clear all have_x flags, and drive m_axis_result_tvalid = 0 and m_axis_result_tdata = 0.
REQ-025 After reset, all four tready outputs SHALL read 1.
REQ-026 Reset asserted in SBOX, MIX or DONE SHALL abort the operation with no tvalid pulse.
REQ-027 Operand registers SHALL need no reset.

Structure
REQ-028 word_t and the op encodings SM4_OP_ED = 1'b0 and SM4_OP_KS = 1'b1 SHALL live in the shared package bitutils.
REQ-029 The state enum SHALL be local to the module.
REQ-030 The S-box SHALL be one sub-module, Sm4Sbox: combinational, 8-bit in, 8-bit out, using the standard SM4 table.
REQ-031 Target size is 120-250 lines of RTL, excluding the S-box table.

Verification
REQ-032 All four channels valid in cycle 0, ED, rs1 = 0, rs2 = 0, bs = 0 -> tvalid in cycle 3 only, tdata = 0x5B5BD58E.
REQ-033 Same operands with KS -> tdata = 0xC01A6BD6.
REQ-034 ED, rs1 = 0xFFFFFFFF, rs2 = 0, bs = 1 -> tdata = 0xA42A71A4; a bench SHALL cover bs = 0..3 against the reference model.
REQ-035 Staggered channels (a at cycle 0, op at 2, b at 5, bs at 7) -> each tready drops after its own capture; tvalid at cycle 10; the result matches the model.
REQ-036 Channels held valid continuously for two operations -> tready is 0 during SBOX, MIX and DONE; two tvalid pulses 4 cycles apart; no extra capture.
REQ-037 rst pulsed while in MIX -> no tvalid, tdata = 0, all tready = 1 on the next cycle, and the next request completes correctly.
